adr_seq_ctrl: RTL
=================

ADR_SEQ_CTRL -- requirements
Module: adr_seq_ctrl

Interface
REQ-001 Parameter SLICES, default 4: number of 3-bit adder passes per operation.
REQ-002 Parameter SW, default 3: slice width in bits; operand width is SLICES*SW (12 by default).
REQ-003 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request pulse; sampled only in state IDLE.
REQ-006 op  input  1  operation select: 0 = add, 1 = subtract (a - b).
REQ-007 a  input  SLICES*SW  first operand.
REQ-008 b  input  SLICES*SW  second operand.
REQ-009 cin  input  1  carry-in for add; ignored when op=1.
REQ-010 busy  output  1  high while an operation is in progress (states RUN and DONE).
REQ-011 done  output  1  one-cycle pulse marking valid sum and cout.
REQ-012 sum  output  SLICES*SW  registered result.
REQ-013 cout  output  1  registered final carry; for subtract, 1 = no borrow.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 When the state is IDLE and start=1 at an edge, the block SHALL perform all of the following on that edge:
- latch a;
- latch b when op=0, or ~b when op=1;
- load the carry register with cin when op=0, or with 1 when op=1;
- clear the slice index to 0;
- go to RUN.
REQ-016 On each edge in RUN, the block SHALL add slice [idx*SW +: SW] of both latched operands plus the carry register.
REQ-017 The slice result SHALL be written to the same bits of sum, and the slice carry-out SHALL be written to the carry register.
REQ-018 In RUN, idx SHALL increment each edge; on the edge where idx = SLICES-1, the FSM SHALL go to DONE and cout SHALL take the slice carry-out.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-020 Latency: start accepted at edge N gives done high between edge N+SLICES and edge N+SLICES+1 (edges N+4 to N+5 by default).
REQ-021 A start asserted in RUN or DONE SHALL be ignored, with no queuing.
REQ-022 Back-to-back operation: the earliest next acceptance is the edge on which the FSM is already in IDLE, which is edge N+SLICES+2.
REQ-023 Changes on a, b, op or cin after acceptance SHALL NOT affect the operation in flight.
REQ-024 sum and cout SHALL hold their values from the end of DONE until the next accepted start.
REQ-025 Between acceptance and done, sum SHALL be partially updated, and the bench SHALL NOT check it before done.
REQ-026 Arithmetic SHALL be modulo 2^(SLICES*SW); cout is the carry out of the most significant slice.

Reset
REQ-027 When rst=1 at an edge, the following SHALL be forced on that edge: state=IDLE, idx=0, carry register=0, busy=0, done=0, sum=0, cout=0.
REQ-028 rst SHALL take priority over start.
REQ-029 rst asserted mid-operation SHALL abort the operation, and no done SHALL follow.

Structure
REQ-030 The state encoding, SW and SLICES defaults SHALL live in the shared package adr_pkg.
REQ-031 The per-pass add SHALL be a separate combinational sub-module, adr_slice3 (inputs x[2:0], y[2:0], cin; outputs sum[2:0], cout).
REQ-032 adr_slice3 SHALL be instantiated exactly once and reused every RUN cycle.
REQ-033 busy SHALL be a decode of the state register.
REQ-034 done SHALL be registered.

Verification
REQ-035 The bench SHALL cover: add, a=12'h0FF, b=12'h001, cin=0 -> sum=12'h100, cout=0, done 4 edges after acceptance.
REQ-036 The bench SHALL cover: add, a=12'hFFF, b=12'h000, cin=1 -> sum=12'h000, cout=1 (wrap-around).
REQ-037 The bench SHALL cover: subtract, a=12'h007, b=12'h005 -> sum=12'h002, cout=1; and a=12'h005, b=12'h007 -> sum=12'hFFE, cout=0.
REQ-038 The bench SHALL cover a start pulse during RUN with different operands -> ignored, first result unchanged, single done pulse.
REQ-039 The bench SHALL cover rst=1 for one cycle two edges after acceptance -> all outputs 0, no done, and a new start accepted on the following edge completes correctly.
REQ-040 The bench SHALL cover start held high continuously -> one operation per 6 edges, done pulses spaced 6 cycles apart, busy low only in IDLE cycles.

Source files
------------

// File: rtl/adr_pkg.sv
// Shared definitions for the sliced sequential adder: default geometry and FSM encoding.
package adr_pkg;

  localparam int unsigned SLICES_DEF = 4;
  localparam int unsigned SW_DEF     = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adr_slice3.sv
// Combinational 3-bit full adder slice, reused once per RUN cycle by adr_seq_ctrl.
module adr_slice3 (
  input  logic [2:0] x,
  input  logic [2:0] y,
  input  logic       cin,
  output logic [2:0] sum,
  output logic       cout
);

  logic [3:0] total_s;

  // Widen by one bit so the carry falls out of the top.
  always_comb begin
    total_s = {1'b0, x} + {1'b0, y} + {3'b000, cin};
  end

  assign sum  = total_s[2:0];
  assign cout = total_s[3];

endmodule

// File: rtl/adr_seq_ctrl.sv
// Sequential adder/subtractor: one shared 3-bit slice walks the operands LSB-first,
// one slice per cycle, then pulses done with the registered sum and carry.
module adr_seq_ctrl
  import adr_pkg::*;
#(
  parameter int unsigned SLICES = SLICES_DEF,
  parameter int unsigned SW     = SW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 op,
  input  logic [SLICES*SW-1:0] a,
  input  logic [SLICES*SW-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [SLICES*SW-1:0] sum,
  output logic                 cout
);

  localparam int unsigned OW = SLICES * SW;
  localparam int unsigned IW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(SLICES - 1);

  state_t          state_r;
  state_t          state_nx_s;
  logic [IW-1:0]   idx_r;
  logic [OW-1:0]   a_r;
  logic [OW-1:0]   b_r;
  logic [OW-1:0]   sum_r;
  logic            carry_r;
  logic            cout_r;
  logic            done_r;
  logic [SW-1:0]   x_s;
  logic [SW-1:0]   y_s;
  logic [SW-1:0]   slice_sum_s;
  logic            slice_cout_s;

  // Select the current slice of both latched operands.
  always_comb begin
    x_s = a_r[idx_r*SW +: SW];
    y_s = b_r[idx_r*SW +: SW];
  end

  adr_slice3 u_slice (
    .x    (x_s),
    .y    (y_s),
    .cin  (carry_r),
    .sum  (slice_sum_s),
    .cout (slice_cout_s)
  );

  // Next-state logic for the three-state sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (idx_r == IDX_LAST) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, operand latches and per-slice accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      done_r  <= (state_nx_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            // Subtract is a + ~b + 1, so the inversion and the +1 happen at latch time.
            a_r     <= a;
            b_r     <= op ? ~b : b;
            carry_r <= op ? 1'b1 : cin;
            idx_r   <= '0;
          end
        end
        ST_RUN: begin
          sum_r[idx_r*SW +: SW] <= slice_sum_s;
          carry_r               <= slice_cout_s;
          idx_r                 <= idx_r + IW'(1);
          if (idx_r == IDX_LAST) begin
            cout_r <= slice_cout_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state_r != ST_IDLE);
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule
